// File: rtl/jtag_pkg.sv
// TAP controller shared types: state encoding, IR width, opcodes.
// Imported by the interface, the IR sub-module and the top.
package jtag_pkg;

  localparam int IR_W = 2;

  localparam logic [IR_W-1:0] OP_EXTEST  = 2'b00;
  localparam logic [IR_W-1:0] OP_BYPASS0 = 2'b01;
  localparam logic [IR_W-1:0] OP_BYPASS1 = 2'b10;
  localparam logic [IR_W-1:0] OP_INTSCAN = 2'b11;

  // Standard 1149.1 state codes
  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

endpackage

// File: rtl/jtag_tap_controller_if.sv
// Pin-side bundle of the TAP: TMS/TDI/chain TDOs in, TDO, tdo_en,
// inst and the BSR/ISR capture/shift/update controls out.
interface jtag_tap_controller_if;
  import jtag_pkg::*;

  logic            TMS;
  logic            TDI;
  logic            TDO_BSR;
  logic            TDO_ISR;
  logic            TDO;
  logic            tdo_en;
  logic [IR_W-1:0] inst;
  logic            clockdr_bs;
  logic            shiftdr_bs;
  logic            updatedr_bs;
  logic            clockdr_is;
  logic            shiftdr_is;
  logic            updatedr_is;

  modport master (
    output TMS, TDI, TDO_BSR, TDO_ISR,
    input  TDO, tdo_en, inst,
    input  clockdr_bs, shiftdr_bs, updatedr_bs,
    input  clockdr_is, shiftdr_is, updatedr_is
  );

  modport slave (
    input  TMS, TDI, TDO_BSR, TDO_ISR,
    output TDO, tdo_en, inst,
    output clockdr_bs, shiftdr_bs, updatedr_bs,
    output clockdr_is, shiftdr_is, updatedr_is
  );

endinterface

// File: rtl/jtag_ir.sv
// Instruction register: capture/shift stage plus update (active) stage.
// Ports: clk, rst, tlr/capture/shift/update strobes, tdi in; lsb, inst out.
module jtag_ir
  import jtag_pkg::*;
#(
  parameter logic [IR_W-1:0] RST_VAL = 2'b01,
  parameter logic [IR_W-1:0] CAP_VAL = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tlr,
  input  logic            capture,
  input  logic            shift,
  input  logic            update,
  input  logic            tdi,
  output logic            lsb,
  output logic [IR_W-1:0] inst
);

  logic [IR_W-1:0] sr;

  // Sitting in Test-Logic-Reset re-applies the reset instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= RST_VAL;
      inst <= RST_VAL;
    end else begin
      unique case (1'b1)
        tlr: begin
          sr   <= RST_VAL;
          inst <= RST_VAL;
        end
        capture: sr   <= CAP_VAL;
        shift:   sr   <= {tdi, sr[IR_W-1:1]};
        update:  inst <= sr;
        default: ;
      endcase
    end
  end

  assign lsb = sr[0];

endmodule

// File: rtl/jtag_tap_controller.sv
// 1149.1 TAP FSM, bypass register, chain select and TDO mux.
// Ports: TCLK, TRST (async, active high), jtag pin bundle (slave).
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter logic [IR_W-1:0] IR_RESET   = 2'b01,
  parameter logic [IR_W-1:0] IR_CAPTURE = 2'b01
) (
  input  logic                  TCLK,
  input  logic                  TRST,
  jtag_tap_controller_if.slave  jtag
);

  tap_state_t state;
  tap_state_t nxt;

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) state <= TLR;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      TLR:    nxt = jtag.TMS ? TLR    : RTI;
      RTI:    if (jtag.TMS) nxt = SEL_DR;
      SEL_DR: nxt = jtag.TMS ? SEL_IR : CAP_DR;
      CAP_DR: nxt = jtag.TMS ? EX1_DR : SH_DR;
      SH_DR:  if (jtag.TMS) nxt = EX1_DR;
      EX1_DR: nxt = jtag.TMS ? UPD_DR : PAU_DR;
      PAU_DR: if (jtag.TMS) nxt = EX2_DR;
      EX2_DR: nxt = jtag.TMS ? UPD_DR : SH_DR;
      UPD_DR: nxt = jtag.TMS ? SEL_DR : RTI;
      SEL_IR: nxt = jtag.TMS ? TLR    : CAP_IR;
      CAP_IR: nxt = jtag.TMS ? EX1_IR : SH_IR;
      SH_IR:  if (jtag.TMS) nxt = EX1_IR;
      EX1_IR: nxt = jtag.TMS ? UPD_IR : PAU_IR;
      PAU_IR: if (jtag.TMS) nxt = EX2_IR;
      EX2_IR: nxt = jtag.TMS ? UPD_IR : SH_IR;
      UPD_IR: nxt = jtag.TMS ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end

  logic st_tlr;
  logic st_cap_dr;
  logic st_sh_dr;
  logic st_upd_dr;
  logic st_cap_ir;
  logic st_sh_ir;
  logic st_upd_ir;

  assign st_tlr    = (state == TLR);
  assign st_cap_dr = (state == CAP_DR);
  assign st_sh_dr  = (state == SH_DR);
  assign st_upd_dr = (state == UPD_DR);
  assign st_cap_ir = (state == CAP_IR);
  assign st_sh_ir  = (state == SH_IR);
  assign st_upd_ir = (state == UPD_IR);

  logic            ir_lsb;
  logic [IR_W-1:0] inst;

  jtag_ir #(
    .RST_VAL (IR_RESET),
    .CAP_VAL (IR_CAPTURE)
  ) u_ir (
    .clk     (TCLK),
    .rst     (TRST),
    .tlr     (st_tlr),
    .capture (st_cap_ir),
    .shift   (st_sh_ir),
    .update  (st_upd_ir),
    .tdi     (jtag.TDI),
    .lsb     (ir_lsb),
    .inst    (inst)
  );

  logic byp;

  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST)           byp <= 1'b0;
    else if (st_cap_dr) byp <= 1'b0;
    else if (st_sh_dr)  byp <= jtag.TDI;
  end

  logic sel_bs;
  logic sel_is;
  logic dr_clk;

  assign sel_bs = (inst == OP_EXTEST);
  assign sel_is = (inst == OP_INTSCAN);
  assign dr_clk = st_cap_dr | st_sh_dr;

  // Pure decodes of registered state: no TMS path, so no glitches
  assign jtag.clockdr_bs  = sel_bs & dr_clk;
  assign jtag.shiftdr_bs  = sel_bs & st_sh_dr;
  assign jtag.updatedr_bs = sel_bs & st_upd_dr;
  assign jtag.clockdr_is  = sel_is & dr_clk;
  assign jtag.shiftdr_is  = sel_is & st_sh_dr;
  assign jtag.updatedr_is = sel_is & st_upd_dr;

  assign jtag.tdo_en = st_sh_dr | st_sh_ir;
  assign jtag.inst   = inst;

  logic tdo;

  always_comb begin
    tdo = 1'b0;
    unique case (1'b1)
      st_sh_ir:                     tdo = ir_lsb;
      st_sh_dr & sel_bs:            tdo = jtag.TDO_BSR;
      st_sh_dr & sel_is:            tdo = jtag.TDO_ISR;
      st_sh_dr & ~sel_bs & ~sel_is: tdo = byp;
      default:                      tdo = 1'b0;
    endcase
  end

  assign jtag.TDO = tdo;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized bench for jtag_tap_controller against a table-driven
// TAP reference model; directed scans for EXTEST/INTSCAN/BYPASS/IR.
module tb_jtag_tap_controller;

  logic TCLK = 1'b0;
  logic TRST;

  always #5 TCLK = ~TCLK;

  jtag_tap_controller_if bus ();

  jtag_tap_controller dut (
    .TCLK (TCLK),
    .TRST (TRST),
    .jtag (bus)
  );

  localparam int S_TLR  = 0;
  localparam int S_RTI  = 1;
  localparam int S_SDR  = 2;
  localparam int S_CDR  = 3;
  localparam int S_SHDR = 4;
  localparam int S_E1DR = 5;
  localparam int S_PDR  = 6;
  localparam int S_E2DR = 7;
  localparam int S_UDR  = 8;
  localparam int S_SIR  = 9;
  localparam int S_CIR  = 10;
  localparam int S_SHIR = 11;
  localparam int S_E1IR = 12;
  localparam int S_PIR  = 13;
  localparam int S_E2IR = 14;
  localparam int S_UIR  = 15;

  localparam int IR_CAP = 1;
  localparam int IR_RST = 1;

  int total = 0;
  int bad   = 0;

  int m_st;
  int m_inst;
  int m_sr;
  int m_byp;

  int c_cb, c_sb, c_ub, c_ci, c_si, c_ui;

  task automatic chk(input string tag, input logic [31:0] got,
                     input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int nxt_st(input int s, input int t);
    case (s)
      S_TLR:  return t ? S_TLR  : S_RTI;
      S_RTI:  return t ? S_SDR  : S_RTI;
      S_SDR:  return t ? S_SIR  : S_CDR;
      S_CDR:  return t ? S_E1DR : S_SHDR;
      S_SHDR: return t ? S_E1DR : S_SHDR;
      S_E1DR: return t ? S_UDR  : S_PDR;
      S_PDR:  return t ? S_E2DR : S_PDR;
      S_E2DR: return t ? S_UDR  : S_SHDR;
      S_UDR:  return t ? S_SDR  : S_RTI;
      S_SIR:  return t ? S_TLR  : S_CIR;
      S_CIR:  return t ? S_E1IR : S_SHIR;
      S_SHIR: return t ? S_E1IR : S_SHIR;
      S_E1IR: return t ? S_UIR  : S_PIR;
      S_PIR:  return t ? S_E2IR : S_PIR;
      S_E2IR: return t ? S_UIR  : S_SHIR;
      default: return t ? S_SDR : S_RTI;
    endcase
  endfunction

  task automatic model_reset();
    m_st   = S_TLR;
    m_inst = IR_RST;
    m_sr   = IR_RST;
    m_byp  = 0;
  endtask

  task automatic model_edge(input int tms, input int tdi);
    case (m_st)
      S_TLR:  begin m_inst = IR_RST; m_sr = IR_RST; end
      S_CIR:  m_sr = IR_CAP;
      S_SHIR: m_sr = (m_sr >> 1) | (tdi << 1);
      S_UIR:  m_inst = m_sr;
      S_CDR:  m_byp = 0;
      S_SHDR: m_byp = tdi;
      default: ;
    endcase
    m_st = nxt_st(m_st, tms);
  endtask

  task automatic compare_all();
    int bs, is, cap, sh, up, en, tdo, ctl;
    bs  = (m_inst == 0);
    is  = (m_inst == 3);
    cap = (m_st == S_CDR) || (m_st == S_SHDR);
    sh  = (m_st == S_SHDR);
    up  = (m_st == S_UDR);
    en  = (m_st == S_SHDR) || (m_st == S_SHIR);
    if (m_st == S_SHIR)  tdo = m_sr & 1;
    else if (!sh)        tdo = 0;
    else if (bs)         tdo = int'(bus.TDO_BSR);
    else if (is)         tdo = int'(bus.TDO_ISR);
    else                 tdo = m_byp;
    ctl = ((bs & cap) << 5) | ((bs & sh) << 4) | ((bs & up) << 3)
        | ((is & cap) << 2) | ((is & sh) << 1) | (is & up);
    chk("ctl", {bus.clockdr_bs, bus.shiftdr_bs, bus.updatedr_bs,
                bus.clockdr_is, bus.shiftdr_is, bus.updatedr_is}, ctl);
    chk("tdo_en", bus.tdo_en, en);
    chk("inst", bus.inst, m_inst);
    chk("tdo", bus.TDO, tdo);
  endtask

  task automatic clr_cnt();
    c_cb = 0; c_sb = 0; c_ub = 0;
    c_ci = 0; c_si = 0; c_ui = 0;
  endtask

  task automatic step(input int tms, input int tdi,
                      input int bsr, input int isr);
    bus.TMS     = tms[0];
    bus.TDI     = tdi[0];
    bus.TDO_BSR = bsr[0];
    bus.TDO_ISR = isr[0];
    @(posedge TCLK);
    model_edge(tms, tdi);
    #1;
    compare_all();
    c_cb += int'(bus.clockdr_bs);
    c_sb += int'(bus.shiftdr_bs);
    c_ub += int'(bus.updatedr_bs);
    c_ci += int'(bus.clockdr_is);
    c_si += int'(bus.shiftdr_is);
    c_ui += int'(bus.updatedr_is);
  endtask

  task automatic rstep(input int tms, input int tdi);
    step(tms, tdi, int'($urandom % 2), int'($urandom % 2));
  endtask

  task automatic do_trst();
    TRST = 1'b1;
    #2;
    model_reset();
    compare_all();
    #3;
    TRST = 1'b0;
  endtask

  // From RTI: load v into the IR, return to RTI
  task automatic load_ir(input int v);
    rstep(1, 0);
    rstep(1, 0);
    rstep(0, 0);
    rstep(0, 0);
    rstep(0, v & 1);
    rstep(1, (v >> 1) & 1);
    rstep(1, 0);
    rstep(0, 0);
  endtask

  // From RTI: capture + four shift cycles with a fixed chain pattern
  task automatic dr_scan(input int pat, input string tag);
    clr_cnt();
    rstep(1, 0);
    rstep(0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, (pat >> i) & 1, (pat >> i) & 1);
      chk(tag, bus.TDO, (pat >> i) & 1);
    end
    rstep(1, 0);
    rstep(1, 0);
    rstep(0, 0);
  endtask

  initial begin
    TRST        = 1'b1;
    bus.TMS     = 1'b0;
    bus.TDI     = 1'b0;
    bus.TDO_BSR = 1'b0;
    bus.TDO_ISR = 1'b0;
    model_reset();
    #12;
    compare_all();
    TRST = 1'b0;

    // IR load of EXTEST; captured 01 seen LSB first
    rstep(0, 0);
    rstep(1, 0);
    rstep(1, 0);
    rstep(0, 0);
    rstep(0, 0);
    chk("ir_cap0", bus.TDO, 1);
    rstep(0, 0);
    chk("ir_cap1", bus.TDO, 0);
    rstep(1, 0);
    rstep(1, 0);
    rstep(0, 0);
    chk("ir_ext", bus.inst, 0);

    // EXTEST scan, TDO_BSR = 1,0,1,1
    dr_scan(4'b1101, "bsr_tdo");
    chk("ext_clk", c_cb, 5);
    chk("ext_sh", c_sb, 4);
    chk("ext_upd", c_ub, 1);
    chk("ext_is", c_ci + c_si + c_ui, 0);

    // INTSCAN scan
    load_ir(3);
    chk("ir_int", bus.inst, 3);
    dr_scan(4'b0110, "isr_tdo");
    chk("int_clk", c_ci, 5);
    chk("int_sh", c_si, 4);
    chk("int_upd", c_ui, 1);
    chk("int_bs", c_cb + c_sb + c_ub, 0);

    // Bypass: TDI 1,0,1 -> TDO 0,1,0
    load_ir(1);
    rstep(1, 0);
    rstep(0, 0);
    rstep(0, 0);
    chk("byp0", bus.TDO, 0);
    rstep(0, 1);
    chk("byp1", bus.TDO, 1);
    rstep(0, 0);
    chk("byp2", bus.TDO, 0);
    rstep(1, 1);
    rstep(1, 0);
    rstep(0, 0);

    // Pause-DR holds everything
    load_ir(0);
    rstep(1, 0);
    rstep(0, 0);
    rstep(1, 0);
    rstep(0, 0);
    for (int i = 0; i < 10; i++) rstep(0, int'($urandom % 2));
    chk("pause_inst", bus.inst, 0);
    rstep(1, 0);
    rstep(1, 0);
    rstep(0, 0);

    // TRST mid-shift
    rstep(1, 0);
    rstep(0, 0);
    rstep(0, 1);
    rstep(0, 0);
    do_trst();
    chk("trst_inst", bus.inst, 1);
    rstep(1, 0);
    chk("trst_ctl", {bus.clockdr_bs, bus.shiftdr_bs, bus.tdo_en}, 0);

    // Five TMS=1 reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 400 && m_st != s; k++)
        rstep(int'($urandom % 2), int'($urandom % 2));
      chk("walk", m_st, s);
      for (int k = 0; k < 5; k++) rstep(1, int'($urandom % 2));
      rstep(1, 0);
      chk("tlr_inst", bus.inst, 1);
      rstep(0, 0);
    end

    // Random traffic with occasional TRST
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 300 == 0) do_trst();
      else rstep(int'($urandom % 3 == 0), int'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
